// File: rtl/adventure_ctrl.sv
// adventure_ctrl: front-end sequencer for the room state machine.
// Turns level-held, debounced buttons into single-cycle move pulses (one
// move at a time), rejects multi-button presses, drives the room FSM's
// game reset, counts moves and latches the game result until restart.
//
// Ports:
//   clk                         system clock, rising edge
//   reset                       asynchronous, active-low reset
//   btn_n/btn_s/btn_e/btn_w     direction buttons (level, synchronous)
//   btn_restart                 restart button (level, synchronous)
//   room_win, room_die          result flags from the room FSM
//   mv_n/mv_s/mv_e/mv_w         one-cycle move pulses to the room FSM
//   game_rst                    active-high reset to the room FSM
//   move_cnt                    accepted move count, saturating
//   busy                        high in any state other than IDLE
//   game_over                   game finished, moves locked
//   result_win                  valid with game_over: 1 = win
//   cmd_reject                  one-cycle pulse on a rejected press
module adventure_ctrl #(
   parameter int RST_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 8,
   parameter int MAX_MOVES     = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_n,
   input  logic             btn_s,
   input  logic             btn_e,
   input  logic             btn_w,
   input  logic             btn_restart,
   input  logic             room_win,
   input  logic             room_die,
   output logic             mv_n,
   output logic             mv_s,
   output logic             mv_e,
   output logic             mv_w,
   output logic             game_rst,
   output logic [CNT_W-1:0] move_cnt,
   output logic             busy,
   output logic             game_over,
   output logic             result_win,
   output logic             cmd_reject
);

   localparam int CMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
   localparam int TW   = $clog2(CMAX + 1);
   localparam logic [TW-1:0]    RST_LOAD    = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_V       = CNT_W'(MAX_MOVES);
   localparam logic             LIMITED     = (MAX_MOVES != 0);

   typedef enum logic [2:0] {
      RST_HOLD,
      IDLE,
      ISSUE,
      SETTLE,
      DONE
   } state_t;

   state_t           state, state_d;
   logic [TW-1:0]    tmr, tmr_d;
   logic [3:0]       dir_q;          // {n,s,e,w} history
   logic             rst_q;
   logic [3:0]       mv_q, mv_d;
   logic [CNT_W-1:0] move_cnt_d;
   logic             game_rst_d, busy_d, game_over_d, result_win_d, cmd_reject_d;

   logic [3:0] btn_dir;
   logic [3:0] press_dir;
   logic       press_rst;
   logic       multi_press;
   logic       single_press;

   assign btn_dir      = {btn_n, btn_s, btn_e, btn_w};
   assign press_dir    = btn_dir & ~dir_q;
   assign press_rst    = btn_restart & ~rst_q;
   // Clearing the lowest set bit leaves something only if two or more are set.
   assign multi_press  = |(press_dir & (press_dir - 4'd1));
   assign single_press = (press_dir != 4'd0) && !multi_press;

   assign {mv_n, mv_s, mv_e, mv_w} = mv_q;

   always_comb begin
      state_d      = state;
      tmr_d        = tmr;
      mv_d         = 4'd0;
      move_cnt_d   = move_cnt;
      game_over_d  = game_over;
      result_win_d = result_win;
      cmd_reject_d = 1'b0;

      if (press_rst) begin
         // Also reloads the hold timer when already in RST_HOLD.
         state_d      = RST_HOLD;
         tmr_d        = RST_LOAD;
         move_cnt_d   = '0;
         game_over_d  = 1'b0;
         result_win_d = 1'b0;
      end else begin
         case (state)
            RST_HOLD: begin
               if (tmr == '0) state_d = IDLE;
               else           tmr_d   = tmr - 1'b1;
            end
            IDLE: begin
               if (room_win || room_die) begin
                  state_d      = DONE;
                  game_over_d  = 1'b1;
                  result_win_d = room_win;
               end else if (single_press) begin
                  state_d    = ISSUE;
                  mv_d       = press_dir;
                  move_cnt_d = (move_cnt == '1) ? move_cnt : move_cnt + CNT_W'(1);
               end else if (multi_press) begin
                  cmd_reject_d = 1'b1;
               end
            end
            ISSUE: begin
               state_d = SETTLE;
               tmr_d   = SETTLE_LOAD;
            end
            SETTLE: begin
               if (tmr != '0) begin
                  tmr_d = tmr - 1'b1;
               end else if (room_win) begin
                  state_d      = DONE;
                  game_over_d  = 1'b1;
                  result_win_d = 1'b1;
               end else if (room_die || (LIMITED && move_cnt == MAX_V)) begin
                  state_d      = DONE;
                  game_over_d  = 1'b1;
                  result_win_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
            DONE:    ;
            default: state_d = RST_HOLD;
         endcase
      end

      game_rst_d = (state_d == RST_HOLD);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RST_HOLD;
         tmr        <= RST_LOAD;
         dir_q      <= 4'hF;
         rst_q      <= 1'b1;
         mv_q       <= 4'd0;
         game_rst   <= 1'b1;
         move_cnt   <= '0;
         busy       <= 1'b1;
         game_over  <= 1'b0;
         result_win <= 1'b0;
         cmd_reject <= 1'b0;
      end else begin
         state      <= state_d;
         tmr        <= tmr_d;
         dir_q      <= btn_dir;
         rst_q      <= btn_restart;
         mv_q       <= mv_d;
         game_rst   <= game_rst_d;
         move_cnt   <= move_cnt_d;
         busy       <= busy_d;
         game_over  <= game_over_d;
         result_win <= result_win_d;
         cmd_reject <= cmd_reject_d;
      end
   end

endmodule

// File: tb/tb_adventure_ctrl.sv
// Directed bench for adventure_ctrl: u0 uses defaults, u1 has MAX_MOVES=3,
// u2 has CNT_W=2. All three share the same stimulus.
module tb_adventure_ctrl;

   logic clk = 1'b0;
   logic reset;
   logic btn_n, btn_s, btn_e, btn_w, btn_restart;
   logic room_win, room_die;

   logic       mv0_n, mv0_s, mv0_e, mv0_w, rst0, busy0, go0, win0, rej0;
   logic [7:0] cnt0;
   logic       mv1_n, mv1_s, mv1_e, mv1_w, rst1, busy1, go1, win1, rej1;
   logic [7:0] cnt1;
   logic       mv2_n, mv2_s, mv2_e, mv2_w, rst2, busy2, go2, win2, rej2;
   logic [1:0] cnt2;

   int errors = 0;
   int checks = 0;
   int pulses0 = 0;

   always #5 clk = ~clk;

   adventure_ctrl u0 (
      .clk(clk), .reset(reset),
      .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
      .btn_restart(btn_restart), .room_win(room_win), .room_die(room_die),
      .mv_n(mv0_n), .mv_s(mv0_s), .mv_e(mv0_e), .mv_w(mv0_w),
      .game_rst(rst0), .move_cnt(cnt0), .busy(busy0), .game_over(go0),
      .result_win(win0), .cmd_reject(rej0)
   );

   adventure_ctrl #(.MAX_MOVES(3)) u1 (
      .clk(clk), .reset(reset),
      .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
      .btn_restart(btn_restart), .room_win(room_win), .room_die(room_die),
      .mv_n(mv1_n), .mv_s(mv1_s), .mv_e(mv1_e), .mv_w(mv1_w),
      .game_rst(rst1), .move_cnt(cnt1), .busy(busy1), .game_over(go1),
      .result_win(win1), .cmd_reject(rej1)
   );

   adventure_ctrl #(.CNT_W(2), .MAX_MOVES(0)) u2 (
      .clk(clk), .reset(reset),
      .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
      .btn_restart(btn_restart), .room_win(room_win), .room_die(room_die),
      .mv_n(mv2_n), .mv_s(mv2_s), .mv_e(mv2_e), .mv_w(mv2_w),
      .game_rst(rst2), .move_cnt(cnt2), .busy(busy2), .game_over(go2),
      .result_win(win2), .cmd_reject(rej2)
   );

   wire [3:0] mv0 = {mv0_n, mv0_s, mv0_e, mv0_w};
   wire [3:0] mv2 = {mv2_n, mv2_s, mv2_e, mv2_w};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_dir(input logic [3:0] d);
      {btn_n, btn_s, btn_e, btn_w} = d;
   endtask

   // Press, check the pulse on u0, release and run to the last SETTLE cycle.
   task automatic move_start(input logic [3:0] d, input int exp_cnt);
      set_dir(d);
      step();
      check("mv_pulse", mv0, d);
      check("mv_cnt", cnt0, exp_cnt);
      check("mv_busy", busy0, 1'b1);
      set_dir(4'd0);
      step();
      check("mv_one_cycle", mv0, 4'd0);
      step();
      check("settle_busy", busy0, 1'b1);
   endtask

   task automatic reset_all();
      reset = 1'b0;
      step();
      reset = 1'b1;
      step(4);
      check("rst_idle", busy0, 1'b0);
   endtask

   // Invariants on u0, sampled at each edge.
   always @(posedge clk) begin
      if (mv0 != 4'd0) begin
         pulses0++;
         check("inv_mv", {28'd0, (mv0 & (mv0 - 4'd1)) == 4'd0, rst0, go0, rej0}, 32'h8);
      end
   end

   initial begin
      reset = 1'b0;
      btn_n = 1'b0; btn_s = 1'b0; btn_w = 1'b0; btn_restart = 1'b0;
      btn_e = 1'b1;
      room_win = 1'b0; room_die = 1'b0;
      step(2);
      check("rst_game_rst", rst0, 1'b1);
      check("rst_busy", busy0, 1'b1);
      check("rst_outs", {mv0, cnt0, go0, win0, rej0}, 32'd0);

      // Release reset with btn_e held.
      reset = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         step();
         check("hold_game_rst", rst0, 1'b1);
      end
      step();
      check("hold_end_game_rst", rst0, 1'b0);
      check("hold_end_busy", busy0, 1'b0);
      step(3);
      check("held_no_move", cnt0, 32'd0);
      btn_e = 1'b0;
      step();

      // Three moves e, s, e.
      move_start(4'b0010, 1); step(); check("idle_after_move", busy0, 1'b0);
      move_start(4'b0100, 2); step();
      move_start(4'b0010, 3); step();
      check("three_moves", cnt0, 32'd3);

      // Ambiguous press.
      set_dir(4'b1001);
      step();
      check("reject_pulse", rej0, 1'b1);
      check("reject_no_mv", mv0, 4'd0);
      check("reject_cnt", cnt0, 32'd3);
      set_dir(4'd0);
      step();
      check("reject_one_cycle", rej0, 1'b0);

      // Press during SETTLE is dropped.
      set_dir(4'b1000);
      step();
      check("n_pulse", mv0, 4'b1000);
      set_dir(4'd0);
      step();
      set_dir(4'b1000);
      step();
      check("settle_no_reject", rej0, 1'b0);
      step();
      step();
      check("settle_drop", {mv0, cnt0}, {4'd0, 8'd4});
      set_dir(4'd0);
      step();

      // Die on last SETTLE cycle.
      move_start(4'b0010, 5);
      room_die = 1'b1;
      step();
      check("die_over", go0, 1'b1);
      check("die_result", win0, 1'b0);
      set_dir(4'b0100);
      step();
      check("done_no_mv", mv0, 4'd0);
      check("done_no_reject", rej0, 1'b0);
      check("done_cnt", cnt0, 32'd5);
      set_dir(4'd0);
      btn_restart = 1'b1;
      room_die = 1'b0;
      step();
      check("restart_rst", rst0, 1'b1);
      check("restart_clear", {cnt0, go0, win0}, 32'd0);
      btn_restart = 1'b0;
      step(3);
      check("restart_hold", rst0, 1'b1);
      step();
      check("restart_done", {rst0, busy0}, 32'd0);
      check("pulse_total", pulses0, 32'd5);

      // Move limit on u1.
      reset_all();
      move_start(4'b0001, 1); step();
      move_start(4'b0001, 2); step();
      check("limit_not_yet", go1, 1'b0);
      move_start(4'b0001, 3); step();
      check("limit_over", go1, 1'b1);
      check("limit_result", win1, 1'b0);

      // Win beats limit on the same exit sample.
      reset_all();
      move_start(4'b0001, 1); step();
      move_start(4'b0001, 2); step();
      move_start(4'b0001, 3);
      room_win = 1'b1;
      step();
      check("win_prio_over", go1, 1'b1);
      check("win_prio_result", win1, 1'b1);
      room_win = 1'b0;

      // Saturation on u2.
      reset_all();
      for (int unsigned i = 1; i <= 5; i++) begin
         move_start(4'b0100, int'(i));
         step();
         check("sat_cnt", cnt2, (i > 3) ? 32'd3 : i);
      end

      // Asynchronous reset mid-SETTLE.
      set_dir(4'b1000);
      step();
      check("pre_areset_mv", mv2, 4'b1000);
      set_dir(4'd0);
      step();
      #2;
      reset = 1'b0;
      #1;
      check("areset_rst_busy", {rst2, busy2}, 32'h3);
      check("areset_outs", {mv2, cnt2, go2, win2, rej2}, 32'd0);
      step();
      reset = 1'b1;
      step(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
